rsa_seq_ctrl: RTL and testbench

Parametrised sequencer that brings the RSA core out of reset, runs one modular-exponentiation operation, and reports completion. It sits between the user/SPI command interface and the RSA datapath. Relative to the first-generation enable logic it adds configurable reset-setup and end-of-computation hold lengths, a programmable watchdog timeout with an error flag, a run-cycle performance counter, synchronous abort, and start re-arm lockout.

---
 rtl/rsa_seq_pkg.sv | 26 ++
 rtl/rsa_seq_wdog.sv | 38 +++
 rtl/rsa_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_rsa_seq_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_seq_pkg.sv
// Shared definitions for the RSA core sequencer: state encoding and the
// width of the phase counter shared by the SETUP and HOLD phases.
package rsa_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_t;

    // Must hold SETUP_CYCLES-1 and EOC_HOLD_CYCLES-1; never narrower than one bit.
    function automatic int phase_cnt_w(input int setup_cycles, input int hold_cycles);
        int w;
        w = 1;
        if ($clog2(setup_cycles) > w) begin
            w = $clog2(setup_cycles);
        end
        if ($clog2(hold_cycles) > w) begin
            w = $clog2(hold_cycles);
        end
        return w;
    endfunction

endpackage

// File: rtl/rsa_seq_wdog.sv
// RUN-phase cycle counter with saturating increment and watchdog compare.
// The expire flag looks at the pre-increment count so the caller can act in the same edge.
module rsa_seq_wdog #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic             w_limit_on;
    logic             w_at_limit;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // A zero limit disables the watchdog, so limit-1 never wraps when it matters.
    assign w_limit_on = (i_limit != '0);
    assign w_at_limit = (r_count == (i_limit - CNT_W'(1)));

    assign o_count  = r_count;
    assign o_expire = w_limit_on && w_at_limit;

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Sequencer that releases the RSA core from reset, supervises one exponentiation
// with a watchdog, and reports completion with a sticky level and a one-cycle pulse.
module rsa_seq_ctrl
    import rsa_seq_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int EOC_HOLD_CYCLES = 2,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic             start_cmd,
    input  logic             stop_cmd,
    input  logic             eoc_int,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic             en_rsa,
    output logic             rst_rsa,
    output logic             eoc,
    output logic             eocp,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] run_cycles
);

    localparam int              PH_W       = phase_cnt_w(SETUP_CYCLES, EOC_HOLD_CYCLES);
    localparam logic [PH_W-1:0] SETUP_LOAD = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0] HOLD_LOAD  = PH_W'(EOC_HOLD_CYCLES - 1);

    seq_state_t      r_state;
    logic            r_armed;
    logic [PH_W-1:0] r_phase;
    logic            r_en_rsa;
    logic            r_rst_rsa;
    logic            r_eoc;
    logic            r_eocp;
    logic            r_busy;
    logic            r_timeout_err;

    logic             w_start_any;
    logic             w_accept;
    logic             w_run_inc;
    logic             w_expire;
    logic [CNT_W-1:0] w_run_cycles;

    assign w_start_any = start | start_cmd;

    // A start fires only after start_any has been seen low in IDLE, so a held level fires once.
    assign w_accept  = !stop_cmd && ena && (r_state == ST_IDLE) && r_armed && w_start_any;
    assign w_run_inc = !stop_cmd && ena && (r_state == ST_RUN);

    rsa_seq_wdog #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk      (clk),
        .rstb     (rstb),
        .i_clr    (w_accept),
        .i_inc    (w_run_inc),
        .i_limit  (timeout_limit),
        .o_count  (w_run_cycles),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= ST_IDLE;
            r_armed       <= 1'b0;
            r_phase       <= '0;
            r_en_rsa      <= 1'b0;
            r_rst_rsa     <= 1'b0;
            r_eoc         <= 1'b0;
            r_eocp        <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else if (stop_cmd) begin
            // Abort overrides the clock enable; run_cycles is left for post-mortem reading.
            r_state       <= ST_IDLE;
            r_armed       <= 1'b0;
            r_en_rsa      <= 1'b0;
            r_rst_rsa     <= 1'b0;
            r_eoc         <= 1'b0;
            r_eocp        <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_start_any) begin
                        r_armed <= 1'b1;
                    end
                    if (w_accept) begin
                        r_armed       <= 1'b0;
                        r_state       <= ST_SETUP;
                        r_phase       <= SETUP_LOAD;
                        r_en_rsa      <= 1'b1;
                        r_rst_rsa     <= 1'b0;
                        r_eoc         <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_phase == '0) begin
                        r_state   <= ST_RUN;
                        r_rst_rsa <= 1'b1;
                    end else begin
                        r_phase <= r_phase - PH_W'(1);
                    end
                end
                ST_RUN: begin
                    // Completion takes precedence over a watchdog expiry in the same cycle.
                    if (eoc_int) begin
                        r_state <= ST_DONE;
                        r_eocp  <= 1'b1;
                    end else if (w_expire) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b1;
                        r_en_rsa      <= 1'b0;
                        r_rst_rsa     <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_HOLD;
                    r_phase <= HOLD_LOAD;
                    r_eocp  <= 1'b0;
                    r_eoc   <= 1'b1;
                end
                ST_HOLD: begin
                    // rst_rsa and eoc stay high in IDLE so the result remains readable.
                    if (r_phase == '0) begin
                        r_state  <= ST_IDLE;
                        r_en_rsa <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_phase <= r_phase - PH_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_en_rsa <= 1'b0;
                    r_busy   <= 1'b0;
                    r_eocp   <= 1'b0;
                end
            endcase
        end
    end

    assign en_rsa      = r_en_rsa;
    assign rst_rsa     = r_rst_rsa;
    assign eoc         = r_eoc;
    assign eocp        = r_eocp;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign run_cycles  = w_run_cycles;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Bench for rsa_seq_ctrl: per-edge vector table, directed corner sequences, and a
// randomized run checked against a timeline model keyed on cycles since start acceptance.
module tb_rsa_seq_ctrl;

    localparam int S     = 2;
    localparam int H     = 2;
    localparam int W     = 8;
    localparam int RCMAX = (1 << W) - 1;

    logic         clk;
    logic         rstb;
    logic         ena;
    logic         start;
    logic         start_cmd;
    logic         stop_cmd;
    logic         eoc_int;
    logic [W-1:0] timeout_limit;
    logic         en_rsa;
    logic         rst_rsa;
    logic         eoc;
    logic         eocp;
    logic         busy;
    logic         timeout_err;
    logic [W-1:0] run_cycles;

    rsa_seq_ctrl #(
        .SETUP_CYCLES    (S),
        .EOC_HOLD_CYCLES (H),
        .CNT_W           (W)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .start         (start),
        .start_cmd     (start_cmd),
        .stop_cmd      (stop_cmd),
        .eoc_int       (eoc_int),
        .timeout_limit (timeout_limit),
        .en_rsa        (en_rsa),
        .rst_rsa       (rst_rsa),
        .eoc           (eoc),
        .eocp          (eocp),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .run_cycles    (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: tracks enabled edges since acceptance (age) and the age at
    // which completion was seen; outputs follow from the documented cycle offsets.
    bit m_active, m_armed, m_terr, m_eoc, m_rst;
    int m_age, m_eoc_age, m_runs;

    task automatic model_reset();
        m_active = 0; m_armed = 0; m_terr = 0; m_eoc = 0; m_rst = 0;
        m_age = 0; m_eoc_age = -1; m_runs = 0;
    endtask

    task automatic model_edge();
        int a;
        int pre;
        if (stop_cmd) begin
            m_active = 0; m_armed = 0; m_terr = 0; m_eoc = 0; m_rst = 0;
            return;
        end
        if (!ena) return;
        if (!m_active) begin
            if (!(start || start_cmd)) begin
                m_armed = 1;
            end else if (m_armed) begin
                m_armed = 0; m_active = 1; m_age = 0; m_eoc_age = -1;
                m_runs = 0; m_terr = 0; m_eoc = 0; m_rst = 0;
            end
            return;
        end
        a = m_age;
        m_age = m_age + 1;
        if (a < S) begin
            if (m_age == S) m_rst = 1;
        end else if (m_eoc_age < 0) begin
            pre = m_runs;
            if (m_runs < RCMAX) m_runs = m_runs + 1;
            if (eoc_int) begin
                m_eoc_age = a;
            end else if (timeout_limit != 0 && pre == int'(timeout_limit) - 1) begin
                m_active = 0; m_terr = 1; m_rst = 0;
            end
        end else begin
            if (m_age == m_eoc_age + 2) m_eoc = 1;
            if (a == m_eoc_age + 1 + H) m_active = 0;
        end
    endtask

    task automatic check_model();
        int exp_eocp;
        exp_eocp = (m_active && m_eoc_age >= 0 && m_age == m_eoc_age + 1) ? 1 : 0;
        chk("model.en_rsa", en_rsa, m_active);
        chk("model.busy", busy, m_active);
        chk("model.rst_rsa", rst_rsa, m_rst);
        chk("model.eoc", eoc, m_eoc);
        chk("model.eocp", eocp, exp_eocp);
        chk("model.timeout_err", timeout_err, m_terr);
        chk("model.run_cycles", run_cycles, m_runs);
    endtask

    // One clock edge: update the model from the inputs that were present at the edge.
    task automatic step();
        @(posedge clk);
        if (!rstb) model_reset();
        else model_edge();
        #1;
        check_model();
    endtask

    task automatic prime();
        start = 0; start_cmd = 0; stop_cmd = 0; eoc_int = 0; ena = 1;
        step();
    endtask

    task automatic chk_outputs(input string tag, input int e_en, input int e_rst, input int e_eoc,
                               input int e_eocp, input int e_busy, input int e_terr, input int e_rc);
        chk({tag, ".en_rsa"}, en_rsa, e_en);
        chk({tag, ".rst_rsa"}, rst_rsa, e_rst);
        chk({tag, ".eoc"}, eoc, e_eoc);
        chk({tag, ".eocp"}, eocp, e_eocp);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".timeout_err"}, timeout_err, e_terr);
        chk({tag, ".run_cycles"}, run_cycles, e_rc);
    endtask

    typedef struct {
        logic       st;
        logic       eoc_in;
        logic       en;
        logic       rst;
        logic       eoc_o;
        logic       eocp_o;
        logic       bsy;
        logic       terr;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got simulation still running, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int rises;
        bit prev_busy;

        // Normal run: start at edge 0, eoc_int at edge 10; entry i = outputs after edge i.
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        for (int i = 3; i <= 9; i++) begin
            tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(i - 2)};
        end
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd8};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd8};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd8};
        for (int i = 13; i <= 15; i++) begin
            tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd8};
        end

        rstb = 0; ena = 1; start = 0; start_cmd = 0; stop_cmd = 0; eoc_int = 0;
        timeout_limit = '0;
        model_reset();
        #1;
        chk_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rstb = 1;

        prime();
        for (int i = 0; i < 16; i++) begin
            start   = tbl[i].st;
            eoc_int = tbl[i].eoc_in;
            step();
            chk($sformatf("norm%0d.en_rsa", i), en_rsa, tbl[i].en);
            chk($sformatf("norm%0d.rst_rsa", i), rst_rsa, tbl[i].rst);
            chk($sformatf("norm%0d.eoc", i), eoc, tbl[i].eoc_o);
            chk($sformatf("norm%0d.eocp", i), eocp, tbl[i].eocp_o);
            chk($sformatf("norm%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("norm%0d.timeout_err", i), timeout_err, tbl[i].terr);
            chk($sformatf("norm%0d.run_cycles", i), run_cycles, tbl[i].rc);
        end
        $display("normal run done");

        // Timeout limit 5 but completion at edge 7: completion wins.
        prime();
        timeout_limit = 8'd5;
        start = 1; step(); start = 0;
        for (int e = 1; e <= 7; e++) begin
            eoc_int = (e == 7);
            step();
        end
        eoc_int = 0;
        chk_outputs("to_eoc.e7", 1, 1, 0, 1, 1, 0, 5);
        for (int e = 8; e <= 12; e++) step();
        chk_outputs("to_eoc.end", 0, 1, 1, 0, 0, 0, 5);
        $display("timeout with completion done");

        // Timeout limit 5 without completion: fires at edge 7 (start via command bit).
        prime();
        start_cmd = 1; step(); start_cmd = 0;
        for (int e = 1; e <= 6; e++) step();
        chk_outputs("to.e6", 1, 1, 0, 0, 1, 0, 4);
        step();
        chk_outputs("to.e7", 0, 0, 0, 0, 0, 1, 5);
        timeout_limit = '0;
        $display("timeout done");

        // Lockout: start held through completion yields exactly one operation.
        prime();
        start = 1;
        rises = 0;
        prev_busy = busy;
        for (int e = 0; e <= 20; e++) begin
            eoc_int = (e == 10);
            step();
            if (e == 0) chk("lock.terr_clear", timeout_err, 0);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        eoc_int = 0;
        chk("lock.ops", rises, 1);
        chk_outputs("lock.idle", 0, 1, 1, 0, 0, 0, 8);
        start = 0; step();
        start = 1; step();
        chk_outputs("lock.rearm", 1, 0, 0, 0, 1, 0, 0);
        stop_cmd = 1; step(); stop_cmd = 0; start = 0;
        $display("lockout done");

        // Abort mid-RUN at edge 6, then again with ena low.
        for (int v = 0; v < 2; v++) begin
            prime();
            start = 1; step(); start = 0;
            for (int e = 1; e <= 5; e++) step();
            stop_cmd = 1;
            ena = (v == 0);
            step();
            stop_cmd = 0; ena = 1;
            chk_outputs($sformatf("abort%0d", v), 0, 0, 0, 0, 0, 0, 3);
        end
        $display("abort done");

        // ena gating: 4 frozen cycles in SETUP and in HOLD.
        prime();
        start = 1; step(); start = 0;
        ena = 0;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk_outputs($sformatf("gate_setup%0d", e), 1, 0, 0, 0, 1, 0, 0);
        end
        ena = 1;
        step();
        chk("gate.e5.rst_rsa", rst_rsa, 0);
        step();
        chk("gate.e6.rst_rsa", rst_rsa, 1);
        step();
        eoc_int = 1; step(); eoc_int = 0;
        chk_outputs("gate.e8", 1, 1, 0, 1, 1, 0, 2);
        step();
        chk_outputs("gate.e9", 1, 1, 1, 0, 1, 0, 2);
        ena = 0;
        for (int e = 10; e <= 13; e++) begin
            step();
            chk_outputs($sformatf("gate_hold%0d", e), 1, 1, 1, 0, 1, 0, 2);
        end
        ena = 1;
        step();
        chk("gate.e14.busy", busy, 1);
        step();
        chk("gate.e15.busy", busy, 0);
        chk("gate.e15.en_rsa", en_rsa, 0);
        $display("ena gating done");

        // Saturation of run_cycles with the watchdog disabled.
        prime();
        start = 1; step(); start = 0;
        for (int e = 0; e < 300; e++) step();
        chk("sat.run_cycles", run_cycles, RCMAX);
        chk("sat.busy", busy, 1);
        eoc_int = 1; step(); eoc_int = 0;
        for (int e = 0; e < 4; e++) step();
        chk_outputs("sat.end", 0, 1, 1, 0, 0, 0, RCMAX);
        $display("saturation done");

        // Asynchronous reset mid-RUN, then start held through reset release.
        prime();
        start = 1; step(); start = 0;
        for (int e = 1; e <= 5; e++) step();
        #3;
        rstb = 0;
        model_reset();
        #1;
        chk_outputs("async_rst", 0, 0, 0, 0, 0, 0, 0);
        start = 1;
        @(posedge clk); #1;
        rstb = 1;
        for (int e = 0; e < 4; e++) begin
            step();
            chk($sformatf("rst_hold%0d.busy", e), busy, 0);
        end
        start = 0; step();
        start = 1; step();
        chk("rst_rearm.busy", busy, 1);
        start = 0;
        stop_cmd = 1; step(); stop_cmd = 0;
        $display("reset done");

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                timeout_limit = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
            end
            if ($urandom_range(0, 7) == 0) start = ~start;
            start_cmd = ($urandom_range(0, 19) == 0);
            stop_cmd  = ($urandom_range(0, 99) == 0);
            eoc_int   = ($urandom_range(0, 11) == 0);
            ena       = ($urandom_range(0, 9) != 0);
            step();
        end
        $display("random traffic done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
